// File: rtl/imem_responder.sv
// Instruction-memory responder: one-cycle registered fetch with alignment/range
// checking, plus a loader port that owns the array while fetch is stalled.
module imem_responder #(
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [31:0]       NOP_WORD  = 32'h0000_0000
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic [ADDR_W-1:0] imaddr,
  input  logic              imce,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              im_err,
  output logic              im_stall,
  input  logic              ld_req,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic [31:0]       fetch_cnt
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic {SERVE, LOAD} state_e;

  state_e            state_q, state_d;
  logic [31:0]       inst_q, inst_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              mem_we;
  logic [31:0]       mem [DEPTH];

  // Offsets wrap modulo 2^ADDR_W, so addresses below BASE_ADDR land out of range.
  logic [ADDR_W-1:0] f_off, l_off;
  logic [IW-1:0]     f_idx, l_idx;
  logic              f_bad, l_bad;

  assign f_off = imaddr - BASE_ADDR;
  assign l_off = ld_addr - BASE_ADDR;
  assign f_idx = f_off[IW+1:2];
  assign l_idx = l_off[IW+1:2];
  assign f_bad = (|f_off[1:0]) | (|f_off[ADDR_W-1:IW+2]);
  assign l_bad = (|l_off[1:0]) | (|l_off[ADDR_W-1:IW+2]);

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    case (state_q)
      SERVE: begin
        if (imce) begin
          vld_d = 1'b1;
          if (f_bad) begin
            inst_d = NOP_WORD;
            err_d  = 1'b1;
          end else begin
            inst_d = mem[f_idx];
            if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
          end
        end
        if (ld_req) state_d = LOAD;
      end
      LOAD: begin
        inst_d = NOP_WORD;
        // ld_ready is high throughout LOAD, so a valid beat is always accepted.
        if (ld_valid) begin
          mem_we = ~l_bad;
          if (ld_last) state_d = SERVE;
        end
      end
      default: state_d = SERVE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q <= SERVE;
      inst_q  <= NOP_WORD;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array is never cleared; a beat coinciding with reset is dropped.
  always_ff @(posedge cpu_clk_50M) begin
    if (mem_we && !cpu_rst) mem[l_idx] <= ld_data;
  end

  assign inst       = inst_q;
  assign inst_valid = vld_q;
  assign im_err     = err_q;
  assign fetch_cnt  = cnt_q;
  assign im_stall   = (state_q == LOAD);
  assign ld_ready   = (state_q == LOAD);
endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: stimulus pushes expected fetch responses,
// a negedge monitor pops and compares whenever inst_valid is presented.
module tb_imem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imaddr;
  logic        imce;
  logic [31:0] inst;
  logic        inst_valid, im_err, im_stall;
  logic        ld_req, ld_valid, ld_ready, ld_last;
  logic [31:0] ld_addr, ld_data;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;
  exp_t expq[$];

  imem_responder dut (
    .cpu_clk_50M(clk), .cpu_rst(rst), .imaddr(imaddr), .imce(imce),
    .inst(inst), .inst_valid(inst_valid), .im_err(im_err), .im_stall(im_stall),
    .ld_req(ld_req), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && inst_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got inst %h err %b expected no response", inst, im_err);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("resp_inst", inst, e.inst);
        chk("resp_err", {31'd0, im_err}, {31'd0, e.err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic e);
    imce   = 1'b1;
    imaddr = a;
    expq.push_back('{inst: d, err: e});
    tick();
  endtask

  task automatic idle();
    imce = 1'b0;
    tick();
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic enter_load();
    ld_req = 1'b1;
    tick();
    ld_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; imce = 1'b0; imaddr = '0;
    ld_req = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    tick(); tick();
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_err", {31'd0, im_err}, 32'd0);
    chk("rst_stall", {31'd0, im_stall}, 32'd0);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    rst = 1'b0;
    tick();

    // 1: preload two words, fetch back-to-back
    enter_load();
    chk("load_stall", {31'd0, im_stall}, 32'd1);
    beat(32'h0, 32'h2401_0005, 1'b0);
    beat(32'h4, 32'h2402_0007, 1'b1);
    chk("load_exit_stall", {31'd0, im_stall}, 32'd0);
    fetch(32'h0, 32'h2401_0005, 1'b0);
    fetch(32'h4, 32'h2402_0007, 1'b0);
    idle();
    chk("cnt_after_two", fetch_cnt, 32'd2);

    // 2: misaligned, out of range, wrapped-high addresses
    fetch(32'h2, 32'h0, 1'b1);
    fetch(32'h1000, 32'h0, 1'b1);
    fetch(32'hFFFF_FFFC, 32'h0, 1'b1);
    idle();
    chk("cnt_after_errs", fetch_cnt, 32'd2);

    // 3+4: fetch alongside ld_req is served; imce held high through LOAD is ignored
    ld_req = 1'b1;
    fetch(32'h0, 32'h2401_0005, 1'b0);
    ld_req = 1'b0;
    imaddr = 32'h4;
    chk("l3_stall", {31'd0, im_stall}, 32'd1);
    chk("l3_ld_ready", {31'd0, ld_ready}, 32'd1);
    beat(32'h0, 32'hAAAA_0001, 1'b0);
    chk("l3_valid_b1", {31'd0, inst_valid}, 32'd0);
    chk("l3_inst_b1", inst, 32'h0);
    beat(32'h4, 32'hBBBB_0002, 1'b0);
    chk("l3_valid_b2", {31'd0, inst_valid}, 32'd0);
    beat(32'h8, 32'hCCCC_0003, 1'b1);
    chk("l3_valid_b3", {31'd0, inst_valid}, 32'd0);
    chk("l3_inst_b3", inst, 32'h0);
    chk("l3_stall_exit", {31'd0, im_stall}, 32'd0);
    chk("l3_ready_exit", {31'd0, ld_ready}, 32'd0);
    chk("l3_cnt_load", fetch_cnt, 32'd3);
    fetch(32'h0, 32'hAAAA_0001, 1'b0);
    fetch(32'h4, 32'hBBBB_0002, 1'b0);
    fetch(32'h8, 32'hCCCC_0003, 1'b0);
    idle();
    chk("l3_cnt_after", fetch_cnt, 32'd6);

    // discarded loader beats: misaligned and out of range must not write
    enter_load();
    beat(32'h6, 32'hDEAD_DEAD, 1'b0);
    beat(32'h1_0000, 32'hBEEF_BEEF, 1'b0);
    beat(32'h14, 32'h7777_7777, 1'b0);
    beat(32'hC, 32'h1111_1111, 1'b1);
    fetch(32'h4, 32'hBBBB_0002, 1'b0);
    fetch(32'h0, 32'hAAAA_0001, 1'b0);
    fetch(32'hC, 32'h1111_1111, 1'b0);
    idle();

    // 5: reset mid-load after one beat
    enter_load();
    beat(32'h10, 32'h5555_5555, 1'b0);
    rst = 1'b1;
    tick();
    chk("r5_stall", {31'd0, im_stall}, 32'd0);
    chk("r5_ready", {31'd0, ld_ready}, 32'd0);
    chk("r5_cnt", fetch_cnt, 32'd0);
    chk("r5_valid", {31'd0, inst_valid}, 32'd0);
    rst = 1'b0;
    fetch(32'h10, 32'h5555_5555, 1'b0);
    fetch(32'h14, 32'h7777_7777, 1'b0);
    idle();
    chk("r5_cnt_after", fetch_cnt, 32'd2);

    // 6: saturation
    dut.cnt_q = 32'hFFFF_FFFE;
    fetch(32'h0, 32'hAAAA_0001, 1'b0);
    fetch(32'h4, 32'hBBBB_0002, 1'b0);
    fetch(32'h8, 32'hCCCC_0003, 1'b0);
    idle();
    chk("sat_cnt", fetch_cnt, 32'hFFFF_FFFF);
    idle();

    chk("queue_drained", expq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder for the fetch stage.
- Accepts the word address and chip-enable driven by instruction fetch, and returns the addressed 32-bit instruction one cycle later.
- Flags misaligned or out-of-range fetches.
- Includes a loader port so a testbench or boot controller can write the program image while fetch is stalled.

Parameters:
- ADDR_W, 32, width of imaddr and ld_addr.
- DEPTH, 1024, number of 32-bit words in the array (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- NOP_WORD, 32'h0000_0000, instruction returned on error or stall.

Ports:
- cpu_clk_50M, in, 1: the single clock; all state updates on the rising edge.
- cpu_rst, in, 1: synchronous, active-high reset.
- imaddr, in, ADDR_W: fetch byte address.
- imce, in, 1: fetch request this cycle.
- inst, out, 32: fetched instruction, registered.
- inst_valid, out, 1: inst holds a valid response to the previous cycle's request.
- im_err, out, 1: previous request was misaligned or out of range.
- im_stall, out, 1: responder busy loading; fetch requests are ignored.
- ld_req, in, 1: loader asks for ownership of the array.
- ld_valid, in, 1: loader write beat valid.
- ld_ready, out, 1: responder accepts loader beat.
- ld_addr, in, ADDR_W: loader byte address.
- ld_data, in, 32: loader write data.
- ld_last, in, 1: final beat of the load burst.
- fetch_cnt, out, 32: count of successful fetches, saturating.

Behaviour:
- Clock and reset: one clock (cpu_clk_50M); reset cpu_rst is synchronous, active-high.
- Reset values:
  - inst=NOP_WORD, inst_valid=0, im_err=0.
  - im_stall=0, ld_ready=0, fetch_cnt=0.
  - FSM enters SERVE.
  - Array contents are not cleared by reset.
- Index and error checks:
  - offset = imaddr - BASE_ADDR (ADDR_W bits, modulo wrap); idx = offset[log2(DEPTH)+1:2].
  - misaligned = offset[1:0] != 0.
  - out_of_range = offset[ADDR_W-1:log2(DEPTH)+2] != 0. An address below BASE_ADDR wraps to a large offset and is therefore out of range.
- FSM state SERVE:
  - im_stall=0, ld_ready=0.
  - If imce=1: next cycle inst_valid=1.
    - On error: inst=NOP_WORD, im_err=1.
    - Otherwise: inst=mem[idx], im_err=0, and fetch_cnt increments, saturating at 32'hFFFF_FFFF.
  - If imce=0: next cycle inst_valid=0 and im_err=0; inst holds its last value.
  - Latency is exactly 1 cycle. Back-to-back requests are supported every cycle with no bubbles.
  - If ld_req=1, the next state is LOAD. A fetch presented in the same cycle is still served normally, so the request in flight is never dropped.
- FSM state LOAD:
  - im_stall=1, ld_ready=1.
  - imce is ignored: next cycle inst_valid=0, im_err=0, inst=NOP_WORD.
  - Each beat with ld_valid & ld_ready writes mem[ld_idx]=ld_data. ld_idx uses the same offset/index rules as fetch.
  - A misaligned or out-of-range loader beat is accepted and discarded; it does not write.
  - A beat with ld_last=1 that is accepted returns the FSM to SERVE the next cycle. That final beat is still written.
  - ld_req is not sampled in LOAD.
- Read-after-load: the first fetch in SERVE following a load sees every word written during LOAD.
- Reset mid-load: the FSM goes to SERVE and outputs return to reset values. Words already written stay written.
- Outputs inst, inst_valid, im_err, im_stall and ld_ready come directly from flops. im_stall and ld_ready are decoded from the registered state.

Test Plan:
1. Reset, then preload mem[0]=32'h2401_0005 and mem[1]=32'h2402_0007 via loader. Fetch 0x0 then 0x4 on consecutive cycles -> inst=2401_0005 then 2402_0007, one cycle after each request; inst_valid=1 both cycles; fetch_cnt=2.
2. Fetch 0x2 -> next cycle inst=NOP_WORD, im_err=1, inst_valid=1, fetch_cnt unchanged. Fetch 0x1000 with DEPTH=1024 -> im_err=1.
3. Assert ld_req together with a fetch of 0x0 -> that fetch returns its data; next cycle im_stall=1, ld_ready=1. Write 3 beats with ld_last on the third -> SERVE resumes after the third beat; fetches return the new data.
4. Hold imce=1 throughout LOAD -> inst_valid=0, inst=NOP_WORD every LOAD cycle; fetch_cnt does not change.
5. Assert cpu_rst mid-load after 1 beat -> next cycle im_stall=0, fetch_cnt=0. Fetch of the written word returns the new value; an unwritten word keeps its old value.
6. Force fetch_cnt near saturation: preload via a hierarchical deposit of 32'hFFFF_FFFE, then perform 3 good fetches -> fetch_cnt sticks at 32'hFFFF_FFFF.
